// File: rtl/evict_wr_arbiter_pkg.sv
// Shared types and defaults for the evict/flush write arbiter.
package evict_wr_arbiter_pkg;

    // Number of write requesters sharing the AXI write path (evict, flush).
    localparam int NUM_WR_REQ = 2;

    // Default AXI geometry used when the top is instantiated without overrides.
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_DATA_WIDTH = 64;
    localparam int AXI_ID_WIDTH   = 4;
    localparam int AXI_ID         = 10;
    localparam int MAX_OUTST_DEF  = 4;

    // Arbiter FSM: waiting for a grant, or driving one AW/W beat pair.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } wr_arb_state_t;

    // Turns a requester index into a one-hot requester mask.
    function automatic logic [NUM_WR_REQ-1:0] idx_to_onehot(input logic idx);
        logic [NUM_WR_REQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/evict_wr_arbiter_rr_arb2.sv
// Two-way round-robin picker: favours the pointed-to requester when it is
// valid, otherwise hands the grant to the other one. Purely combinational.
module rr_arb2
    import evict_wr_arbiter_pkg::*;
(
    input  logic [NUM_WR_REQ-1:0] valid_i,
    input  logic                  ptr_i,
    output logic [NUM_WR_REQ-1:0] gnt_o,
    output logic                  gnt_idx_o
);

    // Pick the preferred index first, fall back to the other; no grant when idle.
    always_comb begin
        gnt_o     = '0;
        gnt_idx_o = ptr_i;
        if (valid_i[ptr_i]) begin
            gnt_idx_o = ptr_i;
        end else begin
            gnt_idx_o = ~ptr_i;
        end
        if (|valid_i) begin
            gnt_o = idx_to_onehot(gnt_idx_o);
        end
    end

endmodule

// File: rtl/evict_wr_arbiter.sv
// Shares the single AXI write channel (AW/W/B) between the dirty-victim evict
// path (req0) and the flush/writeback engine (req1). One single-beat write per
// grant, AW and W presented together; B responses are routed back by bid[0].
module evict_wr_arbiter
    import evict_wr_arbiter_pkg::*;
#(
    parameter int                  ADDR_WIDTH = AXI_ADDR_WIDTH,
    parameter int                  DATA_WIDTH = AXI_DATA_WIDTH,
    parameter int                  ID_WIDTH   = AXI_ID_WIDTH,
    parameter logic [ID_WIDTH-1:0] ID         = ID_WIDTH'(AXI_ID),
    parameter int                  MAX_OUTST  = MAX_OUTST_DEF
) (
    input  logic                             clk,
    input  logic                             rst_n,

    input  logic [NUM_WR_REQ-1:0]            req_valid_i,
    output logic [NUM_WR_REQ-1:0]            req_ready_o,
    input  logic [NUM_WR_REQ*ADDR_WIDTH-1:0] req_addr_i,
    input  logic [NUM_WR_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_WR_REQ-1:0]            done_o,

    output logic [ID_WIDTH-1:0]              awid_o,
    output logic [ADDR_WIDTH-1:0]            awaddr_o,
    output logic                             awvalid_o,
    input  logic                             awready_i,

    output logic [ID_WIDTH-1:0]              wid_o,
    output logic [DATA_WIDTH-1:0]            wdata_o,
    output logic                             wvalid_o,
    input  logic                             wready_i,

    input  logic [ID_WIDTH-1:0]              bid_i,
    input  logic                             bvalid_i,
    output logic                             bready_o,

    output logic [3:0]                       outst_o
);

    localparam logic [3:0] MAX_OUTST_L = 4'(MAX_OUTST);

    wr_arb_state_t state_q, state_d;
    logic          rr_ptr_q, rr_ptr_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [ID_WIDTH-1:0]   id_q, id_d;
    logic [3:0]            outst_q, outst_d;
    logic [NUM_WR_REQ-1:0] done_q, done_d;

    logic [NUM_WR_REQ-1:0] arb_gnt;
    logic                  arb_idx;
    logic                  grant_ok;
    logic                  send_exit;
    logic                  b_accept;
    logic [NUM_WR_REQ-1:0] req_ready;

    rr_arb2 u_rr_arb2 (
        .valid_i   (req_valid_i),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx)
    );

    // A grant needs an idle FSM, a requester and a free outstanding slot.
    // Gating with rst_n keeps req_ready_o low while the block is held in reset.
    assign grant_ok  = rst_n && (state_q == S_IDLE) && (|req_valid_i)
                       && (outst_q < MAX_OUTST_L);

    // The write is counted once both valids have dropped; this is the exit cycle.
    assign send_exit = (state_q == S_SEND) && !awvalid_q && !wvalid_q;

    // A B is legal when something is outstanding or is being counted this very
    // cycle; a stray B is swallowed so the counter never wraps below zero.
    assign b_accept  = bvalid_i && ((outst_q != 4'd0) || send_exit);

    // Next-state logic: grant and latch in IDLE, retire AW/W handshakes in SEND.
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        awvalid_d = awvalid_q;
        wvalid_d  = wvalid_q;
        addr_d    = addr_q;
        data_d    = data_q;
        id_d      = id_q;
        req_ready = '0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_ok) begin
                    req_ready = arb_gnt;
                    addr_d    = req_addr_i[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
                    data_d    = req_data_i[arb_idx*DATA_WIDTH +: DATA_WIDTH];
                    id_d      = {ID[ID_WIDTH-1:1], arb_idx};
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    rr_ptr_d  = ~arb_idx;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                if (awvalid_q && awready_i) begin
                    awvalid_d = 1'b0;
                end
                if (wvalid_q && wready_i) begin
                    wvalid_d = 1'b0;
                end
                if (send_exit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM, round-robin pointer and the registered AW/W payload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            rr_ptr_q  <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            id_q      <= '0;
        end else begin
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            id_q      <= id_d;
        end
    end

    // Outstanding count and B-routing decode; an exit and a B together cancel.
    always_comb begin
        outst_d = outst_q;
        done_d  = '0;
        if (send_exit && !b_accept) begin
            outst_d = outst_q + 4'd1;
        end else if (!send_exit && b_accept) begin
            outst_d = outst_q - 4'd1;
        end
        if (b_accept) begin
            done_d = idx_to_onehot(bid_i[0]);
        end
    end

    // Registered outstanding counter and one-cycle done pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outst_q <= 4'd0;
            done_q  <= '0;
        end else begin
            outst_q <= outst_d;
            done_q  <= done_d;
        end
    end

    assign req_ready_o = req_ready;
    assign done_o      = done_q;
    assign awid_o      = id_q;
    assign wid_o       = id_q;
    assign awaddr_o    = addr_q;
    assign wdata_o     = data_q;
    assign awvalid_o   = awvalid_q;
    assign wvalid_o    = wvalid_q;
    assign bready_o    = 1'b1;
    assign outst_o     = outst_q;

    // A B with nothing outstanding means the controller and arbiter disagree.
    a_no_stray_b: assert property (@(posedge clk) disable iff (!rst_n)
        bvalid_i |-> ((outst_q != 4'd0) || send_exit));

    // B IDs for this port always carry our base ID in the upper bits.
    a_bid_base: assert property (@(posedge clk) disable iff (!rst_n)
        bvalid_i |-> (bid_i[ID_WIDTH-1:1] == ID[ID_WIDTH-1:1]));

    // AW must stay up with a stable payload until it is accepted.
    a_aw_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (awvalid_o && !awready_i) |=> (awvalid_o && $stable(awaddr_o) && $stable(awid_o)));

    // W must stay up with stable data until it is accepted.
    a_w_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (wvalid_o && !wready_i) |=> (wvalid_o && $stable(wdata_o)));

endmodule

// File: tb/tb_evict_wr_arbiter.sv
// Directed bench for evict_wr_arbiter: a scoreboard queue holds the write the
// bench expects on AW/W, pushed when a grant is predicted and popped on AW.
module tb_evict_wr_arbiter;
    import evict_wr_arbiter_pkg::*;

    localparam int AW = AXI_ADDR_WIDTH;
    localparam int DW = AXI_DATA_WIDTH;
    localparam int IW = AXI_ID_WIDTH;
    localparam logic [IW-1:0] BASE_ID = IW'(AXI_ID);

    typedef struct {
        logic          idx;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [1:0]      reqValid;
    logic [1:0]      reqReady;
    logic [2*AW-1:0] reqAddr;
    logic [2*DW-1:0] reqData;
    logic [1:0]      done;
    logic [IW-1:0]   awid;
    logic [AW-1:0]   awaddr;
    logic            awvalid;
    logic            awready;
    logic [IW-1:0]   wid;
    logic [DW-1:0]   wdata;
    logic            wvalid;
    logic            wready;
    logic [IW-1:0]   bid;
    logic            bvalid;
    logic            bready;
    logic [3:0]      outst;

    int   checks;
    int   errors;
    logic tbPtr;
    wr_t  sbQueue[$];

    evict_wr_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid_i (reqValid),
        .req_ready_o (reqReady),
        .req_addr_i  (reqAddr),
        .req_data_i  (reqData),
        .done_o      (done),
        .awid_o      (awid),
        .awaddr_o    (awaddr),
        .awvalid_o   (awvalid),
        .awready_i   (awready),
        .wid_o       (wid),
        .wdata_o     (wdata),
        .wvalid_o    (wvalid),
        .wready_i    (wready),
        .bid_i       (bid),
        .bvalid_i    (bvalid),
        .bready_o    (bready),
        .outst_o     (outst)
    );

    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] v, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        reqValid = v;
        reqAddr  = {a1, a0};
        reqData  = {d1, d0};
    endtask

    task automatic setAxi(input logic awr, input logic wr, input logic bv, input logic bidLsb);
        awready = awr;
        wready  = wr;
        bvalid  = bv;
        bid     = {BASE_ID[IW-1:1], bidLsb};
    endtask

    // Predict the round-robin grant from the bench's own pointer and push the write.
    task automatic expectGrant(input string tag, output logic g);
        wr_t e;
        g = reqValid[tbPtr] ? tbPtr : ~tbPtr;
        checkOutput(tag, 64'(reqReady), 64'(idx_to_onehot(g)));
        e.idx  = g;
        e.addr = g ? reqAddr[2*AW-1:AW] : reqAddr[AW-1:0];
        e.data = g ? reqData[2*DW-1:DW] : reqData[DW-1:0];
        sbQueue.push_back(e);
        tbPtr = ~g;
    endtask

    // Pop the oldest predicted write and compare it against AW/W.
    task automatic expectWrite(input string tag);
        wr_t           e;
        logic [IW-1:0] expId;
        checkOutput({tag, ".sbq"}, 64'(sbQueue.size() != 0), 64'd1);
        if (sbQueue.size() != 0) begin
            e     = sbQueue.pop_front();
            expId = {BASE_ID[IW-1:1], e.idx};
            checkOutput({tag, ".awvalid"}, 64'(awvalid), 64'd1);
            checkOutput({tag, ".wvalid"},  64'(wvalid),  64'd1);
            checkOutput({tag, ".awaddr"},  64'(awaddr),  64'(e.addr));
            checkOutput({tag, ".wdata"},   64'(wdata),   64'(e.data));
            checkOutput({tag, ".awid"},    64'(awid),    64'(expId));
            checkOutput({tag, ".wid"},     64'(wid),     64'(expId));
        end
    endtask

    initial begin
        logic g;
        logic prevIdx;
        logic havePrev;
        checks = 0;
        errors = 0;
        tbPtr  = 1'b0;

        // Reset: even with both requesters valid nothing may be granted.
        rst_n = 1'b0;
        applyStimulus(2'b11, 32'h1000, 64'hA5A5_A5A5_A5A5_A5A5, 32'h1111, 64'h1);
        setAxi(1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        #1;
        checkOutput("rst.req_ready", 64'(reqReady), 64'd0);
        checkOutput("rst.awvalid",   64'(awvalid),  64'd0);
        checkOutput("rst.wvalid",    64'(wvalid),   64'd0);
        checkOutput("rst.done",      64'(done),     64'd0);
        checkOutput("rst.outst",     64'(outst),    64'd0);
        checkOutput("rst.awaddr",    64'(awaddr),   64'd0);
        checkOutput("rst.wdata",     64'(wdata),    64'd0);
        checkOutput("rst.awid",      64'(awid),     64'd0);
        checkOutput("rst.bready",    64'(bready),   64'd1);
        cyc();

        // T1: single write from req0, B routed back to req0.
        applyStimulus(2'b01, 32'h1000, 64'hA5A5_A5A5_A5A5_A5A5, 32'h0, 64'h0);
        rst_n = 1'b1;
        #1;
        expectGrant("t1.grant", g);
        checkOutput("t1.outst0", 64'(outst), 64'd0);
        cyc();
        applyStimulus(2'b00, 32'hDEAD_BEEF, 64'h0, 32'h0, 64'h0);
        #1;
        expectWrite("t1.aw");
        checkOutput("t1.ready_off", 64'(reqReady), 64'd0);
        cyc();
        #1;
        checkOutput("t1.awvalid_drop", 64'(awvalid), 64'd0);
        checkOutput("t1.wvalid_drop",  64'(wvalid),  64'd0);
        cyc();
        #1;
        checkOutput("t1.outst1", 64'(outst), 64'd1);
        setAxi(1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        setAxi(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t1.done",   64'(done),  64'b01);
        checkOutput("t1.outst2", 64'(outst), 64'd0);
        cyc();
        #1;
        checkOutput("t1.done_clear", 64'(done), 64'd0);

        // T2: both requesters valid, grants must alternate; B returned promptly.
        havePrev = 1'b0;
        prevIdx  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b11, 32'h2000 + 32'(i * 64), {32'h00C0_FFEE, 32'(i)},
                          32'h3000 + 32'(i * 64), {32'h0BAD_F00D, 32'(i)});
            if (havePrev) setAxi(1'b1, 1'b1, 1'b1, prevIdx);
            #1;
            checkOutput("t2.outst", 64'(outst), havePrev ? 64'd1 : 64'd0);
            expectGrant("t2.grant", g);
            cyc();
            setAxi(1'b1, 1'b1, 1'b0, 1'b0);
            #1;
            if (havePrev) checkOutput("t2.done", 64'(done), 64'(idx_to_onehot(prevIdx)));
            expectWrite("t2.aw");
            cyc();
            #1;
            checkOutput("t2.awvalid_drop", 64'(awvalid), 64'd0);
            checkOutput("t2.wvalid_drop",  64'(wvalid),  64'd0);
            cyc();
            havePrev = 1'b1;
            prevIdx  = g;
        end
        applyStimulus(2'b00, 32'h0, 64'h0, 32'h0, 64'h0);
        setAxi(1'b1, 1'b1, 1'b1, prevIdx);
        #1;
        checkOutput("t2.outst_last", 64'(outst), 64'd1);
        cyc();
        setAxi(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t2.done_last",  64'(done),  64'(idx_to_onehot(prevIdx)));
        checkOutput("t2.outst_zero", 64'(outst), 64'd0);

        // T3: AW accepted at once, W held off for five cycles.
        applyStimulus(2'b01, 32'h4000, 64'h1234_5678_9ABC_DEF0, 32'h0, 64'h0);
        setAxi(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        expectGrant("t3.grant", g);
        cyc();
        applyStimulus(2'b00, 32'hFFFF_0000, 64'hFFFF, 32'h0, 64'h0);
        #1;
        expectWrite("t3.aw");
        for (int k = 0; k < 4; k++) begin
            cyc();
            #1;
            checkOutput("t3.awvalid_low", 64'(awvalid), 64'd0);
            checkOutput("t3.wvalid_held", 64'(wvalid),  64'd1);
            checkOutput("t3.wdata_held",  64'(wdata),   64'h1234_5678_9ABC_DEF0);
        end
        cyc();
        setAxi(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t3.wvalid_last", 64'(wvalid), 64'd1);
        cyc();
        #1;
        checkOutput("t3.wvalid_drop", 64'(wvalid), 64'd0);
        checkOutput("t3.outst_exit",  64'(outst),  64'd0);
        cyc();
        #1;
        checkOutput("t3.outst1", 64'(outst), 64'd1);
        setAxi(1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        setAxi(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t3.done",   64'(done),  64'b01);
        checkOutput("t3.outst0", 64'(outst), 64'd0);

        // T4: B withheld; exactly four writes, then a stall until a B frees a slot.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'b01, 32'h5000 + 32'(i * 64), {32'h5555_0000, 32'(i)}, 32'h0, 64'h0);
            #1;
            checkOutput("t4.outst", 64'(outst), 64'(i));
            expectGrant("t4.grant", g);
            cyc();
            #1;
            expectWrite("t4.aw");
            cyc();
            cyc();
        end
        #1;
        checkOutput("t4.outst_full", 64'(outst), 64'd4);
        checkOutput("t4.stall",      64'(reqReady), 64'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            #1;
            checkOutput("t4.stall_hold", 64'(reqReady), 64'd0);
        end
        applyStimulus(2'b01, 32'h5800, 64'h5555_5555_0000_0099, 32'h0, 64'h0);
        setAxi(1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        setAxi(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t4.release_done",  64'(done),  64'b01);
        checkOutput("t4.release_outst", 64'(outst), 64'd3);
        expectGrant("t4.release_grant", g);
        cyc();
        #1;
        expectWrite("t4.release_aw");
        cyc();
        cyc();
        #1;
        checkOutput("t4.refull",  64'(outst),    64'd4);
        checkOutput("t4.restall", 64'(reqReady), 64'd0);
        cyc();
        #1;
        checkOutput("t4.restall_hold", 64'(reqReady), 64'd0);

        // T5: drain to two outstanding, then a SEND exit coinciding with a B.
        applyStimulus(2'b00, 32'h0, 64'h0, 32'h0, 64'h0);
        setAxi(1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        #1;
        checkOutput("t5.drain_a", 64'(outst), 64'd3);
        cyc();
        setAxi(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t5.drain_b", 64'(outst), 64'd2);
        applyStimulus(2'b01, 32'h6000, 64'h6666_6666_6666_6666, 32'h0, 64'h0);
        #1;
        expectGrant("t5.grant", g);
        cyc();
        applyStimulus(2'b00, 32'h0, 64'h0, 32'h0, 64'h0);
        #1;
        expectWrite("t5.aw");
        cyc();
        setAxi(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("t5.exit_awvalid", 64'(awvalid), 64'd0);
        checkOutput("t5.exit_outst",   64'(outst),   64'd2);
        cyc();
        setAxi(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t5.outst_same", 64'(outst), 64'd2);
        checkOutput("t5.done_req1",  64'(done),  64'b10);
        setAxi(1'b1, 1'b1, 1'b1, 1'b0);
        cyc();
        #1;
        checkOutput("t5.drain_c", 64'(outst), 64'd1);
        cyc();
        setAxi(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t5.drain_d",      64'(outst), 64'd0);
        checkOutput("t5.drain_d_done", 64'(done),  64'b01);
        cyc();
        #1;
        checkOutput("t5.done_clear", 64'(done), 64'd0);

        // T6: reset while AW/W are pending; afterwards req0 wins the first grant.
        applyStimulus(2'b01, 32'h7000, 64'h7777_7777_7777_7777, 32'h7100, 64'h71);
        setAxi(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        expectGrant("t6.grant", g);
        cyc();
        applyStimulus(2'b11, 32'h7200, 64'h72, 32'h7300, 64'h73);
        #1;
        expectWrite("t6.aw");
        rst_n = 1'b0;
        #1;
        checkOutput("t6.awvalid",   64'(awvalid),  64'd0);
        checkOutput("t6.wvalid",    64'(wvalid),   64'd0);
        checkOutput("t6.req_ready", 64'(reqReady), 64'd0);
        checkOutput("t6.done",      64'(done),     64'd0);
        checkOutput("t6.outst",     64'(outst),    64'd0);
        checkOutput("t6.awaddr",    64'(awaddr),   64'd0);
        checkOutput("t6.wdata",     64'(wdata),    64'd0);
        checkOutput("t6.awid",      64'(awid),     64'd0);
        tbPtr = 1'b0;
        cyc();
        #1;
        checkOutput("t6.ready_in_reset", 64'(reqReady), 64'd0);
        setAxi(1'b1, 1'b1, 1'b0, 1'b0);
        cyc();
        rst_n = 1'b1;
        #1;
        expectGrant("t6.first_grant", g);
        cyc();
        applyStimulus(2'b00, 32'h0, 64'h0, 32'h0, 64'h0);
        #1;
        expectWrite("t6.first_aw");
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
